// File: rtl/ballot_controller_if.sv
// Bus between the ballot sequencer, the officer/button front end and the tally registers.
// vote_inc is a one-cycle strobe with no back-pressure: the tally side must accept it the cycle it is high.
interface ballot_controller_if #(
  parameter int N_CAND = 4,
  parameter int CNT_W  = 8
);
  logic                    arm;
  logic                    mode;
  logic [N_CAND-1:0]       vote_req;
  logic [N_CAND*CNT_W-1:0] cnt_flat;
  logic [N_CAND-1:0]       vote_inc;
  logic                    armed;
  logic                    err;
  logic                    timeout;
  logic [15:0]             ballots;
  logic [7:0]              led;
  logic [2:0]              state_dbg;

  modport master (
    output arm, mode, vote_req, cnt_flat,
    input  vote_inc, armed, err, timeout, ballots, led, state_dbg
  );

  modport slave (
    input  arm, mode, vote_req, cnt_flat,
    output vote_inc, armed, err, timeout, ballots, led, state_dbg
  );
endinterface

// File: rtl/ballot_controller.sv
// Voter-session sequencer: arm, accept exactly one fresh button press, strobe the tally,
// flash the LED, or show a selected tally in result mode.
module ballot_controller #(
  parameter int N_CAND      = 4,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 10,
  parameter int ARM_TIMEOUT = 1000
) (
  input logic               clk,
  input logic               reset,
  ballot_controller_if.slave bus
);
  localparam int SEL_W = (N_CAND > 1) ? $clog2(N_CAND) : 1;
  localparam int TMR_W = $clog2(ARM_TIMEOUT + 1);
  localparam int HLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_COMMIT, S_HOLD, S_SHOW} state_t;

  state_t            state;
  logic [N_CAND-1:0] req_q;
  logic [N_CAND-1:0] rise;
  logic [SEL_W-1:0]  sel;
  logic [SEL_W-1:0]  rise_idx;
  logic [SEL_W-1:0]  low_idx;
  logic [CNT_W-1:0]  rise_tally;
  logic [CNT_W-1:0]  show_tally;
  logic [TMR_W-1:0]  arm_tmr;
  logic [HLD_W-1:0]  hold_cnt;
  logic [CNT_W+7:0]  show_wide;

  assign bus.state_dbg = state;

  always_comb begin
    rise     = bus.vote_req & ~req_q;
    rise_idx = '0;
    low_idx  = sel;
    for (int i = 0; i < N_CAND; i++) begin
      if (rise[i]) rise_idx = SEL_W'(i);
    end
    // Scan downward so the lowest held button wins; nothing held keeps the old selection.
    for (int i = N_CAND - 1; i >= 0; i--) begin
      if (bus.vote_req[i]) low_idx = SEL_W'(i);
    end
    rise_tally = bus.cnt_flat[int'(rise_idx)*CNT_W +: CNT_W];
    show_tally = bus.cnt_flat[int'(low_idx)*CNT_W +: CNT_W];
    show_wide  = {8'h00, show_tally};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      req_q        <= '0;
      sel          <= '0;
      arm_tmr      <= '0;
      hold_cnt     <= '0;
      bus.vote_inc <= '0;
      bus.armed    <= 1'b0;
      bus.err      <= 1'b0;
      bus.timeout  <= 1'b0;
      bus.ballots  <= '0;
      bus.led      <= '0;
    end else begin
      req_q        <= bus.vote_req;
      bus.vote_inc <= '0;
      bus.err      <= 1'b0;
      bus.timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          bus.led <= '0;
          if (bus.mode) begin
            state <= S_SHOW;
          end else if (bus.arm) begin
            state     <= S_ARMED;
            bus.armed <= 1'b1;
            arm_tmr   <= '0;
          end
        end
        S_ARMED: begin
          // Timer saturates so a spoiled press on the last cycle still lets the next quiet cycle expire.
          if (arm_tmr != TMR_W'(ARM_TIMEOUT - 1)) arm_tmr <= arm_tmr + TMR_W'(1);
          if ($countones(rise) == 1) begin
            if (&rise_tally) begin
              bus.err <= 1'b1;
            end else begin
              state        <= S_COMMIT;
              bus.armed    <= 1'b0;
              sel          <= rise_idx;
              bus.vote_inc <= rise;
            end
          end else if ($countones(rise) > 1) begin
            bus.err <= 1'b1;
          end else if (arm_tmr == TMR_W'(ARM_TIMEOUT - 1)) begin
            state       <= S_IDLE;
            bus.armed   <= 1'b0;
            bus.timeout <= 1'b1;
          end
        end
        S_COMMIT: begin
          bus.ballots <= bus.ballots + 16'd1;
          bus.led     <= 8'hFF;
          hold_cnt    <= '0;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == HLD_W'(HOLD_CYCLES - 1)) begin
            state   <= S_IDLE;
            bus.led <= '0;
          end else begin
            hold_cnt <= hold_cnt + HLD_W'(1);
          end
        end
        S_SHOW: begin
          if (!bus.mode) begin
            state   <= S_IDLE;
            bus.led <= '0;
          end else begin
            sel     <= low_idx;
            bus.led <= show_wide[7:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ballot_controller.sv
// Bench for ballot_controller: directed session scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural session model.
module tb_ballot_controller;
  localparam int N_CAND      = 4;
  localparam int CNT_W       = 8;
  localparam int HOLD_CYCLES = 10;
  localparam int ARM_TIMEOUT = 1000;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ballot_controller_if #(.N_CAND(N_CAND), .CNT_W(CNT_W)) bus ();

  ballot_controller #(
    .N_CAND(N_CAND), .CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES), .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural session model
  string       m_st;
  int          m_age;
  int          m_hold;
  int          m_sel;
  logic [3:0]  m_prev;
  logic [3:0]  e_vote_inc;
  logic        e_armed, e_err, e_timeout;
  logic [15:0] e_ballots;
  logic [7:0]  e_led;
  logic [3:0]  exp_q[$];

  function automatic logic [7:0] tally(input int i);
    return bus.cnt_flat[i*CNT_W +: CNT_W];
  endfunction

  task automatic model_reset();
    m_st = "idle"; m_age = 0; m_hold = 0; m_sel = 0; m_prev = '0;
    e_vote_inc = '0; e_armed = 1'b0; e_err = 1'b0; e_timeout = 1'b0;
    e_ballots = '0; e_led = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] rise;
    int n;
    int idx;
    rise = bus.vote_req & ~m_prev;
    n = $countones(rise);
    idx = 0;
    for (int i = 0; i < N_CAND; i++) if (rise[i]) idx = i;
    e_vote_inc = '0; e_err = 1'b0; e_timeout = 1'b0;
    if (m_st == "idle") begin
      e_led = 8'h00;
      if (bus.mode) m_st = "show";
      else if (bus.arm) begin m_st = "armed"; m_age = 0; end
    end else if (m_st == "armed") begin
      if (n == 1) begin
        if (tally(idx) == 8'hFF) e_err = 1'b1;
        else begin
          m_st = "commit"; m_sel = idx; e_vote_inc = rise; exp_q.push_back(rise);
        end
      end else if (n > 1) e_err = 1'b1;
      else if (m_age >= ARM_TIMEOUT - 1) begin m_st = "idle"; e_timeout = 1'b1; end
      m_age++;
    end else if (m_st == "commit") begin
      e_ballots = e_ballots + 16'd1; e_led = 8'hFF; m_hold = HOLD_CYCLES; m_st = "hold";
    end else if (m_st == "hold") begin
      m_hold--;
      if (m_hold == 0) begin m_st = "idle"; e_led = 8'h00; end
    end else if (m_st == "show") begin
      if (!bus.mode) begin m_st = "idle"; e_led = 8'h00; end
      else begin
        for (int i = N_CAND - 1; i >= 0; i--) if (bus.vote_req[i]) m_sel = i;
        e_led = tally(m_sel);
      end
    end
    e_armed = (m_st == "armed");
    m_prev = bus.vote_req;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("vote_inc", 16'(bus.vote_inc), 16'(e_vote_inc));
      chk("armed", 16'(bus.armed), 16'(e_armed));
      chk("err", 16'(bus.err), 16'(e_err));
      chk("timeout", 16'(bus.timeout), 16'(e_timeout));
      chk("ballots", bus.ballots, e_ballots);
      chk("led", 16'(bus.led), 16'(e_led));
      if (bus.vote_inc != '0) begin
        if (exp_q.size() == 0) chk("vote_inc_unexpected", 16'(bus.vote_inc), 16'h0000);
        else chk("vote_inc_sb", 16'(bus.vote_inc), 16'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic arm_once();
    bus.arm = 1'b1; tick(1); bus.arm = 1'b0;
  endtask

  task automatic set_tally(input int i, input logic [7:0] v);
    bus.cnt_flat[i*CNT_W +: CNT_W] = v;
  endtask

  initial begin
    bus.arm = 1'b0; bus.mode = 1'b0; bus.vote_req = '0; bus.cnt_flat = '0;
    reset = 1'b0;
    tick(3);
    chk("reset_led", 16'(bus.led), 16'h0000);
    chk("reset_ballots", bus.ballots, 16'h0000);
    chk("reset_armed", 16'(bus.armed), 16'h0000);
    reset = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // single vote on candidate 1
    arm_once();
    tick(1);
    chk("t1_armed", 16'(bus.armed), 16'h0001);
    bus.vote_req = 4'b0010; tick(1);
    chk("t1_vote_inc", 16'(bus.vote_inc), 16'h0002);
    bus.vote_req = 4'b0000; tick(1);
    chk("t1_ballots", bus.ballots, 16'h0001);
    chk("t1_led_ff", 16'(bus.led), 16'h00FF);
    tick(9);
    chk("t1_led_hold_end", 16'(bus.led), 16'h00FF);
    tick(1);
    chk("t1_led_off", 16'(bus.led), 16'h0000);

    // button held before arming does not vote
    bus.vote_req = 4'b0001; tick(2);
    arm_once(); tick(5);
    chk("t2_still_armed", 16'(bus.armed), 16'h0001);
    bus.vote_req = 4'b0000; tick(1);
    bus.vote_req = 4'b0001; tick(1);
    chk("t2_vote_inc", 16'(bus.vote_inc), 16'h0001);
    bus.vote_req = 4'b0000; tick(12);

    // two simultaneous presses spoil, then a clean press counts
    arm_once();
    bus.vote_req = 4'b0101; tick(1);
    chk("t3_err", 16'(bus.err), 16'h0001);
    chk("t3_armed", 16'(bus.armed), 16'h0001);
    bus.vote_req = 4'b0000; tick(1);
    chk("t3_err_clear", 16'(bus.err), 16'h0000);
    bus.vote_req = 4'b1000; tick(1);
    chk("t3_vote_inc", 16'(bus.vote_inc), 16'h0008);
    bus.vote_req = 4'b0000; tick(12);

    // armed ballot expires after ARM_TIMEOUT cycles
    arm_once();
    tick(ARM_TIMEOUT - 1);
    chk("t4_no_timeout_yet", 16'(bus.timeout), 16'h0000);
    tick(1);
    chk("t4_timeout", 16'(bus.timeout), 16'h0001);
    chk("t4_disarmed", 16'(bus.armed), 16'h0000);
    chk("t4_ballots", bus.ballots, 16'h0003);
    tick(1);

    // full tally rejects the vote; result mode shows tally
    set_tally(1, 8'hFF);
    arm_once();
    bus.vote_req = 4'b0010; tick(1);
    chk("t5_err", 16'(bus.err), 16'h0001);
    chk("t5_no_inc", 16'(bus.vote_inc), 16'h0000);
    bus.vote_req = 4'b0000; tick(ARM_TIMEOUT + 1);
    chk("t5_expired", 16'(bus.armed), 16'h0000);
    set_tally(2, 8'h2A);
    bus.mode = 1'b1; bus.vote_req = 4'b0100; tick(2);
    chk("t5_led_show", 16'(bus.led), 16'h002A);
    bus.vote_req = 4'b0000; tick(1);
    chk("t5_led_sel_held", 16'(bus.led), 16'h002A);
    bus.mode = 1'b0; tick(1);
    chk("t5_led_exit", 16'(bus.led), 16'h0000);
    set_tally(1, 8'h00);

    // asynchronous reset during HOLD
    arm_once();
    bus.vote_req = 4'b0001; tick(1);
    bus.vote_req = 4'b0000; tick(1);
    chk("t6_led_ff", 16'(bus.led), 16'h00FF);
    tick(3);
    reset = 1'b0; #1;
    chk("t6_rst_led", 16'(bus.led), 16'h0000);
    chk("t6_rst_ballots", bus.ballots, 16'h0000);
    tick(1);
    reset = 1'b1;
    tick(1);
    arm_once();
    bus.vote_req = 4'b0100; tick(1);
    bus.vote_req = 4'b0000; tick(1);
    chk("t6_ballots_restart", bus.ballots, 16'h0001);
    tick(12);

    // randomized traffic
    for (int c = 0; c < 6000; c++) begin
      int r;
      if (c % 50 == 0) begin
        for (int i = 0; i < N_CAND; i++)
          set_tally(i, ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 59) == 0) bus.mode = ~bus.mode;
      bus.arm = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r <= 4) bus.vote_req = 4'b0000;
      else if (r <= 7) bus.vote_req = 4'b0001 << $urandom_range(0, 3);
      else if (r == 8) bus.vote_req = 4'($urandom_range(0, 15));
      if (c == 3000) begin
        reset = 1'b0; #2; reset = 1'b1;
      end
      tick(1);
    end
    bus.arm = 1'b0; bus.mode = 1'b0; bus.vote_req = '0;
    tick(HOLD_CYCLES + 5);
    chk("sb_queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
